// File: rtl/nn_address_generator.sv
// Fully-connected layer address generator: walks (neuron, input) pairs neuron-major,
// issuing one registered weight/input address pair per accepted AG_read step.
module nn_address_generator #(
  parameter int N_INPUTS  = 4,
  parameter int N_NEURONS = 4,
  parameter int ADDR_W    = 8,
  parameter int W_BASE    = 0,
  parameter int X_BASE    = 0,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AG_rst,
  input  logic              AG_read,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  output logic [IDX_W-1:0]  neuron_idx,
  output logic              addr_valid,
  output logic              acc_first,
  output logic              acc_last,
  output logic              layer_done
);

  localparam int I_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [I_W-1:0]    i;
  logic [IDX_W-1:0]  n;
  logic [ADDR_W-1:0] wp;
  logic              clear, issue, i_last, n_last;

  assign clear  = reset | AG_rst;
  assign i_last = (i == I_W'(N_INPUTS - 1));
  assign n_last = (n == IDX_W'(N_NEURONS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, RUN: if (AG_read) state_nxt = (i_last && n_last) ? DONE : RUN;
        DONE:      state_nxt = DONE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // DONE swallows AG_read; clear beats a simultaneous read
  always_comb begin
    issue = 1'b0;
    if (!clear && AG_read && (state != DONE)) issue = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      i          <= '0;
      n          <= '0;
      wp         <= ADDR_W'(W_BASE);
      w_addr     <= '0;
      x_addr     <= '0;
      neuron_idx <= '0;
      addr_valid <= 1'b0;
      acc_first  <= 1'b0;
      acc_last   <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      addr_valid <= issue;
      acc_first  <= issue && (i == '0);
      acc_last   <= issue && i_last;
      // registered from state so it trails the final addr_valid by one cycle
      layer_done <= (state == DONE);
      if (issue) begin
        w_addr     <= wp;
        x_addr     <= ADDR_W'(X_BASE) + ADDR_W'(i);
        neuron_idx <= n;
        wp         <= wp + ADDR_W'(1);
        if (i_last) begin
          i <= '0;
          if (!n_last) n <= n + IDX_W'(1);
        end else begin
          i <= i + I_W'(1);
        end
      end
    end
  end

endmodule
